top_stim_capture: RTL and testbench

Self-checking stimulus/response companion for the two-input, single-output registered example design (`in1`, `in2` in; `out` out, all on `clk1`). It sits on the far side of that design's ports.

- Drives both inputs from a 16-bit LFSR.
- Folds the design's `out` into a 16-bit MISR over a programmable number of cycles.
- Compares the final signature against a golden value.
- It is the netlist's pattern source and response reader, used for STA-correlated functional sign-off of remapped netlists.

---
 rtl/top_stim_capture.sv | 147 ++++++++++++++
 tb/tb_top_stim_capture.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/top_stim_capture.sv
`default_nettype none
// ============================================================================
// top_stim_capture : LFSR pattern source and MISR response reader for a
//                    two-input, one-output netlist.          Rev 1.0
// ============================================================================
module top_stim_capture #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int unsigned LAT  = 1
) (
  input  logic        clk1_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [15:0] ncyc_i,
  input  logic [15:0] golden_i,
  input  logic        dut_out_i,
  output logic        dut_in1_o,
  output logic        dut_in2_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] signature_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [15:0]    misr_q, misr_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic           in1_q, in1_d;
  logic           in2_q, in2_d;
  logic           accept;
  logic           issue;
  logic           fold;
  logic           lfb;
  logic           mfb;

  assign accept = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign issue  = (state_q == S_RUN);
  assign fold   = vld_q[LAT-1];
  assign lfb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign mfb    = misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10];

  always_ff @(posedge clk1_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = (ncyc_i == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == 16'd1) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Wait for the last issued pattern's response to be folded.
        if (vld_q == '0) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      S_RUN, S_FLUSH: busy_o = 1'b1;
      S_DONE:         done_o = 1'b1;
      default: ;
    endcase
  end

  assign pass_o = done_o && (misr_q == golden_i);

  // Marks which edges carry a response belonging to an issued pattern.
  generate
    if (LAT == 1) begin : g_vld_single
      assign vld_d = issue;
    end else begin : g_vld_shift
      assign vld_d = {vld_q[LAT-2:0], issue};
    end
  endgenerate

  always_comb begin
    lfsr_d = lfsr_q;
    misr_d = misr_q;
    cnt_d  = cnt_q;
    in1_d  = 1'b0;
    in2_d  = 1'b0;
    if (accept) begin
      lfsr_d = SEED;
      misr_d = '0;
      cnt_d  = ncyc_i;
    end else begin
      if (issue) begin
        in1_d  = lfsr_q[0];
        in2_d  = lfsr_q[1];
        lfsr_d = {lfsr_q[14:0], lfb};
        cnt_d  = cnt_q - 16'd1;
      end
      if (fold) begin
        misr_d = {misr_q[14:0], mfb} ^ {15'b0, dut_out_i};
      end
    end
  end

  always_ff @(posedge clk1_i) begin
    if (!rst_n_i) begin
      lfsr_q <= SEED;
      misr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      in1_q  <= 1'b0;
      in2_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      misr_q <= misr_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
      in1_q  <= in1_d;
      in2_q  <= in2_d;
    end
  end

  assign dut_in1_o   = in1_q;
  assign dut_in2_o   = in2_q;
  assign signature_o = misr_q;

endmodule

`default_nettype wire

// File: tb/tb_top_stim_capture.sv
`default_nettype none
// tb_top_stim_capture : randomized runs against a pattern/signature reference
// model; expected signatures are queued at start and popped when done rises.
module tb_top_stim_capture;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int LAT = 3;
  localparam int M_XOR = 0, M_AND = 1, M_ONE = 2, M_XNOR = 3, M_IN1 = 4, M_PULSE = 5;

  typedef struct packed {
    logic [15:0] sig;
    logic        pass_ok;
  } exp_t;

  logic        clk1 = 1'b0;
  logic        rst_n, start, dut_out, dut_in1, dut_in2, busy, done, pass;
  logic [15:0] ncyc, golden, signature;
  int          mode = M_XOR;
  logic        pulse = 1'b0;
  logic        nl1, nl2;
  logic        done_prev = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [1:0]  exp_pat[$];
  logic [1:0]  cap[4];

  always #5 clk1 = ~clk1;

  top_stim_capture #(.SEED(SEED), .LAT(LAT)) dut (
    .clk1_i     (clk1),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .ncyc_i     (ncyc),
    .golden_i   (golden),
    .dut_out_i  (dut_out),
    .dut_in1_o  (dut_in1),
    .dut_in2_o  (dut_in2),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .signature_o(signature)
  );

  function automatic logic resp(input int md, input logic a, input logic b);
    case (md)
      M_XOR:   return a ^ b;
      M_AND:   return a & b;
      M_ONE:   return 1'b1;
      M_XNOR:  return ~(a ^ b);
      M_IN1:   return a;
      default: return 1'b0;
    endcase
  endfunction

  // Netlist stand-in: two register stages put the response LAT edges after its pattern.
  always @(posedge clk1) begin
    nl1 <= resp(mode, dut_in1, dut_in2);
    nl2 <= nl1;
  end
  assign dut_out = (mode == M_PULSE) ? pulse : nl2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Pattern k is the LFSR state after k-1 steps; fold k samples the response
  // of pattern k (or, in pulse mode, whatever is on dut_out at edge E+LAT+k).
  task automatic model(input int n, input int md, input int pulse_at, output logic [15:0] sig);
    logic [15:0] l;
    logic [15:0] m;
    logic        r;
    l = SEED;
    m = '0;
    exp_pat.delete();
    for (int k = 1; k <= n; k++) begin
      exp_pat.push_back({l[1], l[0]});
      r = (md == M_PULSE) ? (pulse_at == LAT + k) : resp(md, l[0], l[1]);
      m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {15'b0, r};
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    sig = m;
  endtask

  task automatic run(input logic [15:0] n, input int md, input logic [15:0] gold_xor,
                     input int pulse_at, input int glitch_at, input int abort_at);
    logic [15:0] es;
    logic [1:0]  ep;
    exp_t        e;
    int          j, jd, lim, mism;
    model(int'(n), md, pulse_at, es);
    mode   = md;
    golden = es ^ gold_xor;
    ncyc   = n;
    pulse  = 1'b0;
    start  = 1'b1;
    if (abort_at == 0) begin
      e.sig     = es;
      e.pass_ok = (gold_xor == 16'h0000);
      sb.push_back(e);
    end
    tick();
    start = 1'b0;
    jd   = (n == 16'd0) ? 0 : 1 + LAT + int'(n);
    lim  = jd + 20;
    j    = 0;
    mism = 0;
    while (1) begin
      if (j < 4) cap[j] = {dut_in2, dut_in1};
      ep = 2'b00;
      if (j >= 1 && j <= int'(n)) ep = exp_pat[j-1];
      if ({dut_in2, dut_in1} !== ep) mism++;
      if (busy !== (n != 16'd0 && j < jd)) mism++;
      if (abort_at != 0 && j == abort_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_outputs", 32'({busy, done, pass, dut_in1, dut_in2, signature}), 32'd0);
        repeat (LAT + 4) tick();
        chk("abort_no_done", 32'(done), 32'd0);
        return;
      end
      if (done || j >= lim) break;
      pulse = (j + 1 == pulse_at);
      start = (j + 1 == glitch_at);
      if (j + 1 == glitch_at) ncyc = 16'd5;
      tick();
      j++;
    end
    start = 1'b0;
    pulse = 1'b0;
    chk("done_edge", 32'(j), 32'(jd));
    chk("pattern_busy", 32'(mism), 32'd0);
    tick();
  endtask

  always @(negedge clk1) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: done rose with no run pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("signature", 32'(signature), 32'(e.sig));
        chk("pass", 32'(pass), 32'(e.pass_ok));
      end
    end
    done_prev = done;
  end

  initial begin
    logic [15:0] gx;
    logic [15:0] rn;
    int          rm;
    rst_n  = 1'b0;
    start  = 1'b0;
    ncyc   = 16'd0;
    golden = 16'd0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_in1", 32'(dut_in1), 32'd0);
    chk("rst_in2", 32'(dut_in2), 32'd0);
    chk("rst_signature", 32'(signature), 32'd0);
    rst_n = 1'b1;
    tick();

    run(16'd0, M_XOR, 16'h0000, 0, 0, 0);
    chk("zero_signature", 32'(signature), 32'd0);

    run(16'd2, M_XOR, 16'h0000, 0, 0, 0);
    chk("seed_pat1", 32'(cap[1]), 32'h1);
    chk("seed_pat2", 32'(cap[2]), 32'h3);
    chk("seed_pat3", 32'(cap[3]), 32'h0);

    run(16'd3, M_ONE, 16'h0000, 0, 0, 0);
    chk("ones3_signature", 32'(signature), 32'h0007);
    run(16'd4, M_ONE, 16'h0000, 0, 0, 0);
    chk("ones4_signature", 32'(signature), 32'h000F);
    chk("ones4_pass", 32'(pass), 32'd1);
    run(16'd4, M_ONE, 16'h0001, 0, 0, 0);
    chk("ones4_golden_e", 32'(golden), 32'h000E);
    chk("ones4_fail_pass", 32'(pass), 32'd0);

    run(16'd1, M_PULSE, 16'h0000, 4, 0, 0);
    chk("window_e4", 32'(signature), 32'h0001);
    run(16'd1, M_PULSE, 16'h0000, 3, 0, 0);
    chk("window_e3", 32'(signature), 32'h0000);
    run(16'd1, M_PULSE, 16'h0000, 5, 0, 0);
    chk("window_e5", 32'(signature), 32'h0000);

    run(16'd10, M_XOR, 16'h0000, 0, 4, 0);
    run(16'd3, M_XNOR, 16'h0000, 0, 0, 5);
    run(16'd20, M_AND, 16'h0000, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      rn = 16'($urandom_range(1, 40));
      rm = int'($urandom_range(0, 4));
      gx = ($urandom_range(0, 3) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
      run(rn, rm, gx, 0, 0, 0);
    end

    run(16'd1000, M_XOR, 16'h0000, 0, 0, 0);
    chk("closed_loop_pass", 32'(pass), 32'd1);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
